// File: rtl/qpsk_frame_sync.sv
// QPSK frame synchroniser: hunts for a sync word in the dibit stream, then
// assembles a fixed-length payload into bytes and queues them in a small FIFO.
module qpsk_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hF0A5,
  parameter int          SYNC_TOL      = 0,
  parameter int          PAYLOAD_BYTES = 32,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] bit_in,
  input  logic       bit_valid,
  input  logic       error_flag,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_first,
  output logic       byte_last,
  output logic       sync_lock,
  output logic       overflow,
  output logic [7:0] weak_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {HUNT, PAYLOAD} state_t;

  function automatic int popcount16(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] sr, sr_shift;
  logic [1:0]  dibit_cnt;
  logic [7:0]  byte_cnt;
  logic [5:0]  asm_q;
  logic [7:0]  weak_q;
  logic        match, byte_done, is_first, is_last;
  logic [9:0]  push_data;

  // Match is evaluated on the register value that includes the current dibit.
  always_comb begin
    sr_shift  = {sr[13:0], bit_in};
    match     = bit_valid && (state == HUNT) && (popcount16(sr_shift ^ SYNC_WORD) <= SYNC_TOL);
    byte_done = bit_valid && (state == PAYLOAD) && (dibit_cnt == 2'd3);
    is_first  = (byte_cnt == 8'd0);
    is_last   = (byte_cnt == 8'(PAYLOAD_BYTES - 1));
    push_data = {is_first, is_last, asm_q, bit_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (match)                state_nxt = PAYLOAD;
      PAYLOAD: if (byte_done && is_last) state_nxt = HUNT;
      default:                           state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      dibit_cnt <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      weak_q    <= '0;
    end else if (bit_valid) begin
      if (state == HUNT) begin
        sr <= sr_shift;
        if (match) begin
          dibit_cnt <= '0;
          byte_cnt  <= '0;
          weak_q    <= '0;
        end
      end else begin
        asm_q     <= {asm_q[3:0], bit_in};
        dibit_cnt <= dibit_cnt + 2'd1;
        if (error_flag && (weak_q != 8'hFF)) weak_q <= weak_q + 8'd1;
        if (byte_done) begin
          byte_cnt <= is_last ? 8'd0 : byte_cnt + 8'd1;
          if (is_last) sr <= '0;
        end
      end
    end
  end

  // Output FIFO: {first, last, data} per entry.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, pop, wr_en;
  logic [9:0]    head;

  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign pop   = byte_valid && byte_ready;
  assign wr_en = byte_done && (!full || pop);
  assign head  = mem[rd_ptr];

  // NOTE: the storage array has no reset; outputs are gated by byte_valid instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (byte_done && full && !pop) overflow <= 1'b1;
    end
  end

  assign byte_valid = (cnt != '0);
  assign byte_out   = byte_valid ? head[7:0] : 8'd0;
  assign byte_last  = byte_valid & head[8];
  assign byte_first = byte_valid & head[9];
  assign sync_lock  = (state == PAYLOAD);
  assign weak_count = weak_q;

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Scoreboard bench for qpsk_frame_sync: stimulus queues expected bytes, a
// negedge monitor pops and compares them as the DUT hands them out.
module tb_qpsk_frame_sync;

  localparam int PB = 32;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] bit_in;
  logic       bit_valid, error_flag, byte_ready;
  logic [7:0] byte_out, weak_count;
  logic       byte_valid, byte_first, byte_last, sync_lock, overflow;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int pops0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  qpsk_frame_sync #(
    .SYNC_WORD(16'hF0A5), .SYNC_TOL(1), .PAYLOAD_BYTES(PB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .error_flag(error_flag), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_first(byte_first), .byte_last(byte_last),
    .sync_lock(sync_lock), .overflow(overflow), .weak_count(weak_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (byte_valid && byte_ready) begin
        check("sb_expected_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_byte", byte_out, e[7:0]);
          check("sb_first", byte_first, e[9]);
          check("sb_last", byte_last, e[8]);
          pops++;
        end
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d, input logic e);
    bit_in = d; bit_valid = 1'b1; error_flag = e;
    @(posedge clk); #1;
    bit_valid = 1'b0; error_flag = 1'b0; bit_in = 2'b00;
  endtask

  task automatic send_sync(input logic [15:0] w, input logic exp_lock, input string tag);
    for (int k = 7; k >= 1; k--) send_dibit(w[2*k+1 -: 2], 1'b0);
    check({tag, "_lock_pre"}, sync_lock, 0);
    send_dibit(w[1:0], 1'b0);
    check({tag, "_lock"}, sync_lock, exp_lock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] emask,
                           input logic rdy_pulse, input logic expect_out, input int idx);
    if (expect_out) exp_q.push_back({(idx == 0), (idx == PB - 1), b});
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && rdy_pulse) byte_ready = 1'b1;
      send_dibit(b[7-2*k -: 2], emask[k]);
      if (k == 3 && rdy_pulse) byte_ready = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_valid"}, byte_valid, 0);
    check({tag, "_byte_out"},   byte_out,   0);
    check({tag, "_byte_first"}, byte_first, 0);
    check({tag, "_byte_last"},  byte_last,  0);
    check({tag, "_sync_lock"},  sync_lock,  0);
    check({tag, "_overflow"},   overflow,   0);
    check({tag, "_weak_count"}, weak_count, 0);
  endtask

  initial begin
    reset = 1'b1; bit_in = 2'b00; bit_valid = 1'b0; error_flag = 1'b0; byte_ready = 1'b0;
    #12;
    check_all_zero("rst");
    @(posedge clk); #1 reset = 1'b0;

    // Nominal frame, consumer always ready.
    byte_ready = 1'b1;
    send_sync(16'hF0A5, 1'b1, "t1");
    for (int i = 0; i < PB; i++) send_byte(8'(i), 4'h0, 1'b0, 1'b1, i);
    check("t1_unlock", sync_lock, 0);
    check("t1_overflow", overflow, 0);
    idle(3);
    check("t1_pops", pops, 32);

    // One-bit tolerance; sync word inside payload is plain data.
    send_sync(16'hF0A4, 1'b1, "t2_tol1");
    for (int i = 0; i < PB; i++) begin
      send_byte((i == 0) ? 8'hF0 : (i == 1) ? 8'hA5 : 8'(i * 3), 4'h0, 1'b0, 1'b1, i);
      if (i == 2) check("t2_sync_in_payload", sync_lock, 1);
    end
    check("t2_unlock", sync_lock, 0);
    send_sync(16'hF0A6, 1'b0, "t2_dist2");

    // Consumer stalled for a whole frame: only the first FD bytes survive.
    byte_ready = 1'b0;
    do_reset();
    send_sync(16'hF0A5, 1'b1, "t3");
    for (int i = 0; i < PB; i++) send_byte(8'(i), 4'h0, 1'b0, (i < FD), i);
    check("t3_overflow", overflow, 1);
    check("t3_unlock", sync_lock, 0);
    check("t3_head_valid", byte_valid, 1);
    check("t3_head_first", byte_first, 1);
    idle(2);
    check("t3_head_stable", byte_out, 8'h00);
    pops0 = pops;
    byte_ready = 1'b1;
    idle(8);
    check("t3_drained_count", pops - pops0, FD);
    check("t3_empty", byte_valid, 0);
    check("t3_overflow_sticky", overflow, 1);

    // Reset mid-payload (inside byte 10) with bytes held in the FIFO.
    send_sync(16'hF0A5, 1'b1, "t4");
    for (int i = 0; i < 10; i++) begin
      if (i == 8) byte_ready = 1'b0;
      send_byte(8'(8'h80 + i), (i == 5) ? 4'hF : 4'h0, 1'b0, 1'b1, i);
    end
    send_dibit(2'b10, 1'b0);
    send_dibit(2'b10, 1'b0);
    check("t4_pre_weak", weak_count, 4);
    check("t4_pre_valid", byte_valid, 1);
    check("t4_pre_overflow", overflow, 1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("t4_async");
    @(posedge clk); #1 reset = 1'b0;
    byte_ready = 1'b1;
    send_sync(16'hF0A5, 1'b1, "t4_resync");
    for (int i = 0; i < PB; i++) send_byte(8'(8'h40 + i), 4'h0, 1'b0, 1'b1, i);
    idle(3);
    check("t4_overflow_clear", overflow, 0);
    check("t4_drained", exp_q.size(), 0);

    // Full FIFO, ready pulsed on the push edge: push and pop both accepted.
    byte_ready = 1'b0;
    do_reset();
    send_sync(16'hF0A5, 1'b1, "t5");
    for (int i = 0; i < 4; i++) send_byte(8'(i), 4'h0, 1'b0, 1'b1, i);
    send_byte(8'd4, 4'h0, 1'b1, 1'b1, 4);
    check("t5_no_overflow", overflow, 0);
    check("t5_head_after_pop", byte_out, 8'h01);
    byte_ready = 1'b1;
    for (int i = 5; i < PB; i++) send_byte(8'(i), 4'h0, 1'b0, 1'b1, i);
    idle(6);
    check("t5_overflow_end", overflow, 0);
    check("t5_drained", exp_q.size(), 0);

    // Weak-symbol counting: 2 + 3 flagged payload dibits.
    send_sync(16'hF0A5, 1'b1, "t6");
    for (int i = 0; i < PB; i++)
      send_byte(8'(8'hC0 + i), (i == 3) ? 4'b0011 : (i == 20) ? 4'b0111 : 4'b0000, 1'b0, 1'b1, i);
    check("t6_weak_end", weak_count, 5);
    for (int i = 0; i < 4; i++) send_dibit(2'b00, 1'b1);
    check("t6_weak_hunt_hold", weak_count, 5);
    check("t6_hunt", sync_lock, 0);
    send_sync(16'hF0A5, 1'b1, "t6_resync");
    check("t6_weak_cleared", weak_count, 0);

    idle(3);
    check("sb_final_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_frame_sync.md
QPSK_FRAME_SYNC -- requirements
Module: qpsk_frame_sync

Interface
- REQ-001 SHALL have parameter SYNC_WORD, default 16'hF0A5: frame sync pattern, MSB received first.
- REQ-002 SHALL have parameter SYNC_TOL, default 0: max Hamming distance accepted as a sync match (0..3).
- REQ-003 SHALL have parameter PAYLOAD_BYTES, default 32: bytes per frame after sync (2..255).
- REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output byte buffer entries (power of 2, >=2).
- REQ-005 SHALL have port clk  input  1: single clock, all logic on rising edge.
- REQ-006 SHALL have port reset  input  1: asynchronous, active-high reset.
- REQ-007 SHALL have port bit_in  input  2: demodulated dibit; bit_in[1] is the earlier bit.
- REQ-008 SHALL have port bit_valid  input  1: bit_in is valid this cycle.
- REQ-009 SHALL have port error_flag  input  1: weak-symbol flag, qualified by bit_valid.
- REQ-010 SHALL have port byte_out  output  8: head-of-FIFO payload byte, MSB received first.
- REQ-011 SHALL have port byte_valid  output  1: FIFO non-empty.
- REQ-012 SHALL have port byte_ready  input  1: consumer accepts byte_out when byte_valid and byte_ready are both high.
- REQ-013 SHALL have port byte_first  output  1: head byte is payload byte 0 of its frame.
- REQ-014 SHALL have port byte_last  output  1: head byte is payload byte PAYLOAD_BYTES-1.
- REQ-015 SHALL have port sync_lock  output  1: high while in PAYLOAD state.
- REQ-016 SHALL have port overflow  output  1: sticky FIFO-overflow indicator.
- REQ-017 SHALL have port weak_count  output  8: count of error_flag dibits in the current or last frame, saturating at 255.

Function
- REQ-018 SHALL implement states HUNT and PAYLOAD; inputs are ignored on cycles with bit_valid low.
- REQ-019 SHALL, in HUNT, on each valid dibit update a 16-bit shift register as {sr[13:0], bit_in}.
- REQ-020 SHALL declare a match when the Hamming distance between the updated register value and SYNC_WORD is at most SYNC_TOL; the check is performed at dibit granularity only.
- REQ-021 SHALL, on a match, enter PAYLOAD on the next edge, clear the dibit counter (0..3), clear the byte counter (0..PAYLOAD_BYTES-1), and clear weak_count.
- REQ-022 SHALL, in PAYLOAD, shift valid dibits MSB-first into a byte assembler; on the 4th dibit, push the assembled byte with its first/last tags into the FIFO in the same edge.
- REQ-023 SHALL, after pushing byte PAYLOAD_BYTES-1, return to HUNT and clear the shift register to 0.
- REQ-024 SHALL increment weak_count (saturating at 255) on each valid dibit with error_flag high while in PAYLOAD; weak_count holds its value in HUNT.
- REQ-025 SHALL raise byte_valid on the cycle after a push into an empty FIFO (push-to-output latency of 1 cycle).
- REQ-026 SHALL pop the head entry on any edge where byte_valid and byte_ready are both high; byte_out, byte_first, and byte_last remain stable while byte_valid is high and byte_ready is low.
- REQ-027 SHALL accept both a push and a pop on the same edge when full; this case is not an overflow.
- REQ-028 SHALL, on a push with the FIFO full and no pop, drop the new byte, set overflow, and continue frame counting unchanged.
- REQ-029 SHALL keep overflow set until reset.
- REQ-030 SHALL perform no sync search during PAYLOAD; a sync pattern inside the payload is treated as data.

Reset
- REQ-031 SHALL, on reset assertion (asynchronous, any state, mid-frame included), immediately force: state HUNT, shift register 0, counters 0, FIFO empty, byte_out 0, byte_valid 0, byte_first 0, byte_last 0, sync_lock 0, overflow 0, weak_count 0.
- REQ-032 SHALL resume normal operation on the first rising clk edge after reset deasserts; bytes held before reset are discarded.

Verification
- REQ-033 SHALL cover: dibits of 16'hF0A5, then 32 payload bytes 0x00..0x1F, with byte_ready held high -> sync_lock rises after the 8th dibit; 32 bytes are output in order; byte_first is set on 0x00; byte_last is set on 0x1F; sync_lock falls after the last byte.
- REQ-034 SHALL cover: SYNC_TOL=1 with 16'hF0A4 sent -> lock acquired; 16'hF0A6 (2 bits differ) sent -> no lock.
- REQ-035 SHALL cover: byte_ready low for a full frame, FIFO_DEPTH=4 -> bytes 0..3 retained, overflow=1, sync_lock falls after byte 31; on releasing ready, exactly 4 bytes 0x00..0x03 are output.
- REQ-036 SHALL cover: FIFO full with byte_ready pulsed on the same cycle as a push -> no overflow, count stays 4.
- REQ-037 SHALL cover: reset asserted mid-payload (byte 10), between clock edges -> all outputs 0 before the next edge; after release, a new sync and frame are received correctly.
- REQ-038 SHALL cover: 5 payload dibits with error_flag=1 -> weak_count=5 at frame end, held through HUNT, and cleared at the next sync.
